// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - records drum key presses into 100-slot note vectors for playback loading
// Slot 0 of a take ends up at bit 99 once the vectors are full.
module song_recorder (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        beat_tick,
    input  logic        start,
    input  logic        stop,
    input  logic        key_red,
    input  logic        key_yellow,
    input  logic        key_blue,
    output logic [99:0] rec_red,
    output logic [99:0] rec_yellow,
    output logic [99:0] rec_blue,
    output logic [7:0]  total_notes,
    output logic [6:0]  slot_count,
    output logic        recording,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RECORD, PAD, DONE} state_t;

    state_t     state, state_next;
    logic [2:0] keys, prev_keys, key_edge, pending, slot_bits;
    logic       do_clear, do_commit, do_pad, do_discard;
    logic       last_slot;

    // Bit order everywhere: [2] red, [1] yellow, [0] blue.
    assign keys      = {key_red, key_yellow, key_blue};
    assign key_edge  = keys & ~prev_keys;
    assign slot_bits = pending | key_edge;
    assign last_slot = (slot_count >= 7'd99);

    assign recording = (state == RECORD);
    assign done      = (state == DONE);

    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_commit  = 1'b0;
        do_pad     = 1'b0;
        do_discard = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    do_clear   = 1'b1;
                    state_next = RECORD;
                end
            end
            RECORD: begin
                if (beat_tick) begin
                    do_commit = 1'b1;
                    if (last_slot)
                        state_next = DONE;
                    else if (stop)
                        state_next = PAD;
                end else if (stop) begin
                    do_discard = 1'b1;
                    state_next = PAD;
                end
            end
            PAD: begin
                do_pad = 1'b1;
                if (last_slot)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            prev_keys   <= 3'b000;
            pending     <= 3'b000;
            rec_red     <= '0;
            rec_yellow  <= '0;
            rec_blue    <= '0;
            total_notes <= 8'd0;
            slot_count  <= 7'd0;
        end else begin
            state     <= state_next;
            prev_keys <= keys;
            if (do_clear) begin
                pending     <= 3'b000;
                rec_red     <= '0;
                rec_yellow  <= '0;
                rec_blue    <= '0;
                total_notes <= 8'd0;
                slot_count  <= 7'd0;
            end else if (do_commit) begin
                // An edge arriving with the tick belongs to the slot being closed.
                rec_red     <= {rec_red[98:0],    slot_bits[2]};
                rec_yellow  <= {rec_yellow[98:0], slot_bits[1]};
                rec_blue    <= {rec_blue[98:0],   slot_bits[0]};
                total_notes <= total_notes + {7'd0, |slot_bits};
                slot_count  <= slot_count + 7'd1;
                pending     <= 3'b000;
            end else if (do_pad) begin
                rec_red    <= {rec_red[98:0],    1'b0};
                rec_yellow <= {rec_yellow[98:0], 1'b0};
                rec_blue   <= {rec_blue[98:0],   1'b0};
                slot_count <= slot_count + 7'd1;
            end else if (do_discard) begin
                pending <= 3'b000;
            end else if (state == RECORD) begin
                pending <= pending | key_edge;
            end
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed and randomized checks of song_recorder against a slot-list model
module tb_song_recorder;

    logic        clk = 1'b0;
    logic        reset_b, beat_tick, start, stop, key_red, key_yellow, key_blue;
    logic [99:0] rec_red, rec_yellow, rec_blue;
    logic [7:0]  total_notes;
    logic [6:0]  slot_count;
    logic        recording, done;

    int tests_run = 0;
    int tests_failed = 0;

    song_recorder dut (
        .clk(clk), .reset_b(reset_b), .beat_tick(beat_tick), .start(start), .stop(stop),
        .key_red(key_red), .key_yellow(key_yellow), .key_blue(key_blue),
        .rec_red(rec_red), .rec_yellow(rec_yellow), .rec_blue(rec_blue),
        .total_notes(total_notes), .slot_count(slot_count),
        .recording(recording), .done(done)
    );

    always #5 clk = ~clk;

    // Model: a take is the ordered list of committed slots, each a {red,yellow,blue} triple.
    typedef enum {M_IDLE, M_REC, M_PAD, M_DONE} mode_t;
    mode_t      m_mode = M_IDLE;
    logic [2:0] m_slots[$];
    logic [2:0] m_pend = 3'b000;
    logic [2:0] m_prev = 3'b000;

    function automatic logic [99:0] model_vec(int c);
        logic [99:0] v;
        int n;
        v = '0;
        n = m_slots.size();
        for (int j = 0; j < n; j++) v[n-1-j] = m_slots[j][c];
        return v;
    endfunction

    function automatic int model_total();
        int t;
        t = 0;
        foreach (m_slots[j]) if (m_slots[j] != 3'b000) t++;
        return t;
    endfunction

    task automatic model_step();
        logic [2:0] kb, e;
        kb = {key_red, key_yellow, key_blue};
        e  = kb & ~m_prev;
        case (m_mode)
            M_IDLE, M_DONE: if (start) begin
                m_slots.delete();
                m_pend = 3'b000;
                m_mode = M_REC;
            end
            M_REC: begin
                if (beat_tick) begin
                    m_slots.push_back(m_pend | e);
                    m_pend = 3'b000;
                    if (m_slots.size() == 100) m_mode = M_DONE;
                    else if (stop) m_mode = M_PAD;
                end else if (stop) begin
                    m_pend = 3'b000;
                    m_mode = M_PAD;
                end else begin
                    m_pend = m_pend | e;
                end
            end
            M_PAD: begin
                m_slots.push_back(3'b000);
                if (m_slots.size() == 100) m_mode = M_DONE;
            end
        endcase
        m_prev = kb;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        beat_tick = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
    endtask

    task automatic beats(int n);
        repeat (n) begin
            beat_tick = 1'b1;
            tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
    endtask

    task automatic assert_reset();
        reset_b = 1'b0;
        m_mode  = M_IDLE;
        m_slots.delete();
        m_pend  = 3'b000;
        m_prev  = 3'b000;
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        assert_reset();
        tests_run++;
        if ({rec_red, rec_yellow, rec_blue, total_notes, slot_count, recording, done} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got slot=%0d total=%0d rec=%b done=%b, want all 0",
                     slot_count, total_notes, recording, done);
        end
        release_reset();
        beats(1);
        stop = 1'b1;
        tick();
        tests_run++;
        if (slot_count !== 7'd0 || recording !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ignores_tick: got slot=%0d rec=%b done=%b, want 0 0 0",
                     slot_count, recording, done);
        end
    endtask

    task automatic test_full_take();
        logic [99:0] er, eb;
        er = '0; er[99] = 1'b1;
        eb = '0; eb[97] = 1'b1;
        pulse_start();
        tests_run++;
        if (recording !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_recording: got %b want 1", recording);
        end
        key_red = 1'b1; tick(); key_red = 1'b0;
        beats(2);
        key_blue = 1'b1; tick(); key_blue = 1'b0;
        beats(98);
        tests_run++;
        if (done !== 1'b1 || recording !== 1'b0 || slot_count !== 7'd100 || total_notes !== 8'd2) begin
            tests_failed++;
            $display("FAIL full_counters: got done=%b rec=%b slot=%0d total=%0d, want 1 0 100 2",
                     done, recording, slot_count, total_notes);
        end
        tests_run++;
        if (rec_red !== er || rec_yellow !== '0 || rec_blue !== eb) begin
            tests_failed++;
            $display("FAIL full_vectors: got r=%h y=%h b=%h want r=%h y=0 b=%h",
                     rec_red, rec_yellow, rec_blue, er, eb);
        end
    endtask

    task automatic test_early_stop();
        logic [99:0] ey;
        int pad;
        ey = '0; ey[99] = 1'b1;
        pulse_start();
        key_yellow = 1'b1; tick(); key_yellow = 1'b0;
        beats(3);
        stop = 1'b1;
        tick();
        tests_run++;
        if (slot_count !== 7'd3 || recording !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL stop_enters_pad: got slot=%0d rec=%b done=%b want 3 0 0",
                     slot_count, recording, done);
        end
        pad = 0;
        while (done !== 1'b1 && pad < 200) begin
            tick();
            pad++;
        end
        tests_run++;
        if (pad !== 97) begin
            tests_failed++;
            $display("FAIL pad_cycles: got %0d want 97", pad);
        end
        tests_run++;
        if (rec_yellow !== ey || rec_red !== '0 || rec_blue !== '0
            || slot_count !== 7'd100 || total_notes !== 8'd1) begin
            tests_failed++;
            $display("FAIL early_stop_result: got y=%h slot=%0d total=%0d want y=%h slot=100 total=1",
                     rec_yellow, slot_count, total_notes, ey);
        end
    endtask

    task automatic test_simultaneous();
        logic [99:0] er;
        er = '0; er[99] = 1'b1;
        pulse_start();
        key_red   = 1'b1;
        beat_tick = 1'b1;
        tick();
        key_red = 1'b0;
        tests_run++;
        if (rec_red[0] !== 1'b1 || slot_count !== 7'd1 || total_notes !== 8'd1) begin
            tests_failed++;
            $display("FAIL edge_with_tick: got bit0=%b slot=%0d total=%0d want 1 1 1",
                     rec_red[0], slot_count, total_notes);
        end
        beats(98);
        beat_tick = 1'b1;
        stop      = 1'b1;
        tick();
        tests_run++;
        if (done !== 1'b1 || slot_count !== 7'd100 || rec_red !== er) begin
            tests_failed++;
            $display("FAIL stop_tick_last_slot: got done=%b slot=%0d r=%h want 1 100 %h",
                     done, slot_count, rec_red, er);
        end
    endtask

    task automatic test_edge_rules();
        key_blue = 1'b1;
        tick();
        pulse_start();
        beats(5);
        tests_run++;
        if (rec_blue !== '0 || slot_count !== 7'd5 || total_notes !== 8'd0) begin
            tests_failed++;
            $display("FAIL held_key: got b=%h slot=%0d total=%0d want 0 5 0",
                     rec_blue, slot_count, total_notes);
        end
        key_blue = 1'b0;
        key_red = 1'b1; tick(); key_red = 1'b0; tick();
        key_red = 1'b1; tick(); key_red = 1'b0;
        beats(1);
        tests_run++;
        if (rec_red !== 100'd1 || total_notes !== 8'd1 || slot_count !== 7'd6) begin
            tests_failed++;
            $display("FAIL double_edge: got r=%h total=%0d slot=%0d want 1 1 6",
                     rec_red, total_notes, slot_count);
        end
    endtask

    task automatic test_reset_mid_record();
        key_yellow = 1'b1; tick(); key_yellow = 1'b0;
        beats(34);
        tests_run++;
        if (slot_count !== 7'd40 || recording !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_slots: got slot=%0d rec=%b want 40 1", slot_count, recording);
        end
        assert_reset();
        tests_run++;
        if ({rec_red, rec_yellow, rec_blue, total_notes, slot_count, recording, done} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got slot=%0d total=%0d rec=%b want all 0",
                     slot_count, total_notes, recording);
        end
        release_reset();
        beats(1);
        tests_run++;
        if ({rec_red, rec_yellow, rec_blue, total_notes, slot_count, recording, done} !== '0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got slot=%0d total=%0d rec=%b want all 0",
                     slot_count, total_notes, recording);
        end
    endtask

    task automatic test_restart();
        logic [99:0] ey;
        ey = '0; ey[99] = 1'b1;
        pulse_start();
        key_yellow = 1'b1; tick(); key_yellow = 1'b0;
        beats(100);
        key_red = 1'b1;
        beat_tick = 1'b1;
        stop = 1'b1;
        tick();
        key_red = 1'b0;
        tick();
        tests_run++;
        if (done !== 1'b1 || rec_yellow !== ey || rec_red !== '0 || slot_count !== 7'd100
            || total_notes !== 8'd1) begin
            tests_failed++;
            $display("FAIL done_holds: got done=%b y=%h r=%h slot=%0d total=%0d",
                     done, rec_yellow, rec_red, slot_count, total_notes);
        end
        pulse_start();
        tests_run++;
        if ({rec_red, rec_yellow, rec_blue, total_notes, slot_count} !== '0 || recording !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_clear: got slot=%0d total=%0d rec=%b want 0 0 1",
                     slot_count, total_notes, recording);
        end
        beats(2);
        pulse_start();
        tests_run++;
        if (slot_count !== 7'd2 || recording !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_in_record: got slot=%0d rec=%b want 2 1", slot_count, recording);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            beat_tick  = ($urandom_range(0, 3) == 0);
            start      = ($urandom_range(0, 40) == 0);
            stop       = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 4) == 0) key_red    = ~key_red;
            if ($urandom_range(0, 4) == 0) key_yellow = ~key_yellow;
            if ($urandom_range(0, 4) == 0) key_blue   = ~key_blue;
            tick();
            tests_run++;
            if (rec_red !== model_vec(2) || rec_yellow !== model_vec(1) || rec_blue !== model_vec(0)) begin
                tests_failed++;
                $display("FAIL rand_vectors cyc=%0d: got r=%h y=%h b=%h want r=%h y=%h b=%h", cyc,
                         rec_red, rec_yellow, rec_blue, model_vec(2), model_vec(1), model_vec(0));
            end
            tests_run++;
            if (slot_count !== 7'(m_slots.size()) || total_notes !== 8'(model_total())) begin
                tests_failed++;
                $display("FAIL rand_counts cyc=%0d: got slot=%0d total=%0d want slot=%0d total=%0d",
                         cyc, slot_count, total_notes, m_slots.size(), model_total());
            end
            tests_run++;
            if (recording !== (m_mode == M_REC) || done !== (m_mode == M_DONE)) begin
                tests_failed++;
                $display("FAIL rand_flags cyc=%0d: got rec=%b done=%b want rec=%b done=%b",
                         cyc, recording, done, m_mode == M_REC, m_mode == M_DONE);
            end
        end
    endtask

    initial begin
        reset_b = 1'b0; beat_tick = 1'b0; start = 1'b0; stop = 1'b0;
        key_red = 1'b0; key_yellow = 1'b0; key_blue = 1'b0;
        #12;
        test_reset();
        test_full_take();
        test_early_stop();
        test_simultaneous();
        test_edge_rules();
        test_reset_mid_record();
        test_restart();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
